// File: rtl/operand_fwd_stage_pkg.sv
// Shared types for the ID/EX operand forwarding stage.
// Holds the operand select encodings, FSM states and datapath default.
package operand_fwd_stage_pkg;

    localparam int XLEN_DEF = 32;

    typedef enum logic [1:0] {
        SRC1_RS   = 2'b00,
        SRC1_PC   = 2'b01,
        SRC1_ZERO = 2'b10
    } src1_sel_e;

    typedef enum logic [1:0] {
        SRC2_RS   = 2'b00,
        SRC2_IMM  = 2'b01,
        SRC2_FOUR = 2'b10,
        SRC2_ZERO = 2'b11
    } src2_sel_e;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        FULL  = 2'b01,
        HAZ   = 2'b10
    } state_e;

endpackage

// File: rtl/operand_fwd_stage_fwd_select.sv
// Resolves one source register against NFWD forwarding sources.
// Ports: i_addr/i_rf_data in, packed fwd bundle in, o_value/o_pending out.
module fwd_select #(
    parameter int NFWD = 2,
    parameter int AW   = 5,
    parameter int XLEN = 32
) (
    input  logic [AW-1:0]        i_addr,
    input  logic [XLEN-1:0]      i_rf_data,
    input  logic [NFWD-1:0]      i_fwd_valid,
    input  logic [NFWD-1:0]      i_fwd_pending,
    input  logic [NFWD*AW-1:0]   i_fwd_rd_addr,
    input  logic [NFWD*XLEN-1:0] i_fwd_data,
    output logic [XLEN-1:0]      o_value,
    output logic                 o_pending
);

    logic            w_hit;
    logic [XLEN-1:0] w_value;
    logic            w_pending;

    // Source 0 is youngest; first hit in ascending order wins.
    always_comb begin
        w_hit     = 1'b0;
        w_value   = i_rf_data;
        w_pending = 1'b0;
        for (int k = 0; k < NFWD; k++) begin
            if (!w_hit && i_fwd_valid[k] &&
                i_fwd_rd_addr[k*AW +: AW] == i_addr) begin
                w_hit     = 1'b1;
                w_value   = i_fwd_data[k*XLEN +: XLEN];
                w_pending = i_fwd_pending[k];
            end
        end
        // x0 is never forwarded and never stalls.
        if (i_addr == '0) begin
            w_value   = '0;
            w_pending = 1'b0;
        end
    end

    assign o_value   = w_value;
    assign o_pending = w_pending;

endmodule

// File: rtl/operand_fwd_stage.sv
// ID/EX operand stage: forwarding, load-use bubbles, EX register.
// Ports: ID bundle in, fwd bundle in, EX operands out, stall monitor out.
module operand_fwd_stage
    import operand_fwd_stage_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NFWD = 2,
    parameter int AW   = 5,
    parameter int CNTW = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_flush,
    input  logic                 i_id_valid,
    output logic                 o_id_ready,
    input  logic [AW-1:0]        i_id_rs1_addr,
    input  logic [AW-1:0]        i_id_rs2_addr,
    input  logic                 i_id_rs1_used,
    input  logic                 i_id_rs2_used,
    input  logic [XLEN-1:0]      i_id_rs1_data,
    input  logic [XLEN-1:0]      i_id_rs2_data,
    input  logic [XLEN-1:0]      i_id_pc,
    input  logic [XLEN-1:0]      i_id_imm,
    input  logic [1:0]           i_id_src1_sel,
    input  logic [1:0]           i_id_src2_sel,
    input  logic [NFWD-1:0]      i_fwd_valid,
    input  logic [NFWD-1:0]      i_fwd_pending,
    input  logic [NFWD*AW-1:0]   i_fwd_rd_addr,
    input  logic [NFWD*XLEN-1:0] i_fwd_data,
    output logic                 o_ex_valid,
    input  logic                 i_ex_ready,
    output logic [XLEN-1:0]      o_ex_op1,
    output logic [XLEN-1:0]      o_ex_op2,
    output logic [XLEN-1:0]      o_ex_rs2_val,
    output logic [XLEN-1:0]      o_ex_rs1_val,
    output logic                 o_hazard_stall,
    output logic [CNTW-1:0]      o_stall_cnt
);

    localparam logic [XLEN-1:0] FOUR    = XLEN'(4);
    localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_rs2_val;
    logic            w_rs1_pend;
    logic            w_rs2_pend;
    logic            w_hazard;
    logic            w_ready;
    logic            w_capture;
    logic            w_ex_valid;
    logic [XLEN-1:0] w_op1;
    logic [XLEN-1:0] w_op2;
    state_e          r_state;
    state_e          w_state_nxt;
    logic [XLEN-1:0] r_op1;
    logic [XLEN-1:0] r_op2;
    logic [XLEN-1:0] r_rs1_val;
    logic [XLEN-1:0] r_rs2_val;
    logic [CNTW-1:0] r_stall_cnt;

    fwd_select #(.NFWD(NFWD), .AW(AW), .XLEN(XLEN)) u_fwd_rs1 (
        .i_addr        (i_id_rs1_addr),
        .i_rf_data     (i_id_rs1_data),
        .i_fwd_valid   (i_fwd_valid),
        .i_fwd_pending (i_fwd_pending),
        .i_fwd_rd_addr (i_fwd_rd_addr),
        .i_fwd_data    (i_fwd_data),
        .o_value       (w_rs1_val),
        .o_pending     (w_rs1_pend)
    );

    fwd_select #(.NFWD(NFWD), .AW(AW), .XLEN(XLEN)) u_fwd_rs2 (
        .i_addr        (i_id_rs2_addr),
        .i_rf_data     (i_id_rs2_data),
        .i_fwd_valid   (i_fwd_valid),
        .i_fwd_pending (i_fwd_pending),
        .i_fwd_rd_addr (i_fwd_rd_addr),
        .i_fwd_data    (i_fwd_data),
        .o_value       (w_rs2_val),
        .o_pending     (w_rs2_pend)
    );

    // Only a pending winning hit on a used operand stalls.
    assign w_hazard = i_id_valid &&
                      ((i_id_rs1_used && w_rs1_pend) ||
                       (i_id_rs2_used && w_rs2_pend));

    assign w_ready   = !w_hazard && (!w_ex_valid || i_ex_ready) && !i_flush;
    assign w_capture = i_id_valid && w_ready;

    always_comb begin
        unique case (i_id_src1_sel)
            SRC1_RS: w_op1 = w_rs1_val;
            SRC1_PC: w_op1 = i_id_pc;
            default: w_op1 = '0;
        endcase
    end

    always_comb begin
        unique case (i_id_src2_sel)
            SRC2_RS:   w_op2 = w_rs2_val;
            SRC2_IMM:  w_op2 = i_id_imm;
            SRC2_FOUR: w_op2 = FOUR;
            default:   w_op2 = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (i_flush) begin
            w_state_nxt = EMPTY;
        end else begin
            unique case (r_state)
                EMPTY: begin
                    if (w_capture)     w_state_nxt = FULL;
                    else if (w_hazard) w_state_nxt = HAZ;
                end
                FULL: begin
                    if (i_ex_ready) begin
                        if (w_capture)     w_state_nxt = FULL;
                        else if (w_hazard) w_state_nxt = HAZ;
                        else               w_state_nxt = EMPTY;
                    end
                end
                HAZ: begin
                    if (w_capture) w_state_nxt = FULL;
                end
                default: w_state_nxt = EMPTY;
            endcase
        end
    end

    always_comb begin
        w_ex_valid = (r_state == FULL);
    end

    // Operands are left untouched by flush; ex_valid alone qualifies them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op1     <= '0;
            r_op2     <= '0;
            r_rs1_val <= '0;
            r_rs2_val <= '0;
        end else if (w_capture) begin
            r_op1     <= w_op1;
            r_op2     <= w_op2;
            r_rs1_val <= w_rs1_val;
            r_rs2_val <= w_rs2_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_hazard && r_stall_cnt != '1) begin
            r_stall_cnt <= r_stall_cnt + CNT_ONE;
        end
    end

    assign o_id_ready     = w_ready;
    assign o_ex_valid     = w_ex_valid;
    assign o_ex_op1       = r_op1;
    assign o_ex_op2       = r_op2;
    assign o_ex_rs1_val   = r_rs1_val;
    assign o_ex_rs2_val   = r_rs2_val;
    assign o_hazard_stall = w_hazard;
    assign o_stall_cnt    = r_stall_cnt;

endmodule

// File: tb/tb_operand_fwd_stage.sv
// Bench for operand_fwd_stage: directed cases plus random traffic
// compared against a transaction-level model of the EX register.
module tb_operand_fwd_stage;

    localparam int XLEN = 32;
    localparam int NFWD = 2;
    localparam int AW   = 5;
    localparam int CNTW = 16;
    localparam int CMAX = (1 << CNTW) - 1;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 flush;
    logic                 id_valid;
    logic                 id_ready;
    logic [AW-1:0]        rs1_addr, rs2_addr;
    logic                 rs1_used, rs2_used;
    logic [XLEN-1:0]      rs1_data, rs2_data;
    logic [XLEN-1:0]      pc, imm;
    logic [1:0]           src1_sel, src2_sel;
    logic [NFWD-1:0]      fv, fpend;
    logic [AW-1:0]        frd [NFWD];
    logic [XLEN-1:0]      fd  [NFWD];
    logic [NFWD*AW-1:0]   fwd_rd_addr;
    logic [NFWD*XLEN-1:0] fwd_data;
    logic                 ex_valid, ex_ready;
    logic [XLEN-1:0]      ex_op1, ex_op2, ex_rs1_val, ex_rs2_val;
    logic                 hazard_stall;
    logic [CNTW-1:0]      stall_cnt;

    always #5 clk = ~clk;

    always_comb begin
        fwd_rd_addr = '0;
        fwd_data    = '0;
        for (int k = 0; k < NFWD; k++) begin
            fwd_rd_addr[k*AW +: AW] = frd[k];
            fwd_data[k*XLEN +: XLEN] = fd[k];
        end
    end

    operand_fwd_stage #(
        .XLEN(XLEN), .NFWD(NFWD), .AW(AW), .CNTW(CNTW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_flush        (flush),
        .i_id_valid     (id_valid),
        .o_id_ready     (id_ready),
        .i_id_rs1_addr  (rs1_addr),
        .i_id_rs2_addr  (rs2_addr),
        .i_id_rs1_used  (rs1_used),
        .i_id_rs2_used  (rs2_used),
        .i_id_rs1_data  (rs1_data),
        .i_id_rs2_data  (rs2_data),
        .i_id_pc        (pc),
        .i_id_imm       (imm),
        .i_id_src1_sel  (src1_sel),
        .i_id_src2_sel  (src2_sel),
        .i_fwd_valid    (fv),
        .i_fwd_pending  (fpend),
        .i_fwd_rd_addr  (fwd_rd_addr),
        .i_fwd_data     (fwd_data),
        .o_ex_valid     (ex_valid),
        .i_ex_ready     (ex_ready),
        .o_ex_op1       (ex_op1),
        .o_ex_op2       (ex_op2),
        .o_ex_rs2_val   (ex_rs2_val),
        .o_ex_rs1_val   (ex_rs1_val),
        .o_hazard_stall (hazard_stall),
        .o_stall_cnt    (stall_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Model of what EX should hold.
    bit              m_valid;
    logic [XLEN-1:0] m_op1, m_op2, m_rs1, m_rs2;
    int              m_cnt;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Youngest source is visited last so it overrides older ones.
    function automatic void resolve(input logic [AW-1:0] a,
                                    input logic [XLEN-1:0] rf,
                                    output logic [XLEN-1:0] v,
                                    output bit p);
        v = rf;
        p = 1'b0;
        for (int k = NFWD - 1; k >= 0; k--) begin
            if (fv[k] && frd[k] == a) begin
                v = fd[k];
                p = fpend[k];
            end
        end
        if (a == 0) begin
            v = '0;
            p = 1'b0;
        end
    endfunction

    task automatic model_reset();
        m_valid = 0;
        m_op1 = '0; m_op2 = '0; m_rs1 = '0; m_rs2 = '0;
        m_cnt = 0;
    endtask

    task automatic set_idle();
        id_valid = 0; flush = 0; ex_ready = 1;
        rs1_addr = '0; rs2_addr = '0;
        rs1_used = 0; rs2_used = 0;
        rs1_data = '0; rs2_data = '0;
        pc = '0; imm = '0;
        src1_sel = 2'd0; src2_sel = 2'd0;
        fv = '0; fpend = '0;
        for (int k = 0; k < NFWD; k++) begin
            frd[k] = '0;
            fd[k] = '0;
        end
    endtask

    // Called just after a falling edge with inputs driven.
    task automatic tick();
        logic [XLEN-1:0] v1, v2, o1, o2;
        bit p1, p2, haz, rdy, cap;
        #1;
        resolve(rs1_addr, rs1_data, v1, p1);
        resolve(rs2_addr, rs2_data, v2, p2);
        haz = id_valid && ((rs1_used && p1) || (rs2_used && p2));
        rdy = !haz && (!m_valid || ex_ready) && !flush;
        cap = id_valid && rdy;
        case (src1_sel)
            2'd0: o1 = v1;
            2'd1: o1 = pc;
            default: o1 = '0;
        endcase
        case (src2_sel)
            2'd0: o2 = v2;
            2'd1: o2 = imm;
            2'd2: o2 = 32'd4;
            default: o2 = '0;
        endcase
        check("hazard_stall", hazard_stall, haz);
        check("id_ready", id_ready, rdy);
        check("ex_valid", ex_valid, m_valid);
        check("stall_cnt", stall_cnt, m_cnt);
        if (m_valid) begin
            check("ex_op1", ex_op1, m_op1);
            check("ex_op2", ex_op2, m_op2);
            check("ex_rs1_val", ex_rs1_val, m_rs1);
            check("ex_rs2_val", ex_rs2_val, m_rs2);
        end
        if (flush) begin
            m_valid = 0;
        end else if (cap) begin
            m_valid = 1;
            m_op1 = o1; m_op2 = o2; m_rs1 = v1; m_rs2 = v2;
        end else if (!(m_valid && !ex_ready)) begin
            m_valid = 0;
        end
        if (haz && m_cnt < CMAX) m_cnt++;
        @(negedge clk);
    endtask

    task automatic drive_random();
        id_valid = $urandom_range(0, 9) < 8;
        rs1_addr = AW'($urandom_range(0, 7));
        rs2_addr = AW'($urandom_range(0, 7));
        rs1_used = $urandom_range(0, 3) != 0;
        rs2_used = $urandom_range(0, 1) != 0;
        rs1_data = $urandom;
        rs2_data = $urandom;
        pc = $urandom;
        imm = $urandom;
        src1_sel = 2'($urandom_range(0, 3));
        src2_sel = 2'($urandom_range(0, 3));
        for (int k = 0; k < NFWD; k++) begin
            fv[k] = $urandom_range(0, 3) != 0;
            fpend[k] = $urandom_range(0, 3) == 0;
            frd[k] = AW'($urandom_range(0, 7));
            fd[k] = $urandom;
        end
        ex_ready = $urandom_range(0, 3) != 0;
        flush = $urandom_range(0, 19) == 0;
    endtask

    initial begin
        int c0;
        rst_n = 0;
        set_idle();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_ex_valid", ex_valid, 0);
        check("rst_op1", ex_op1, 0);
        check("rst_op2", ex_op2, 0);
        check("rst_rs1", ex_rs1_val, 0);
        check("rst_rs2", ex_rs2_val, 0);
        check("rst_cnt", stall_cnt, 0);
        @(negedge clk);
        rst_n = 1;
        tick();

        // Youngest source wins when both match x5.
        id_valid = 1; rs1_addr = 5; rs1_used = 1; rs1_data = 32'h99;
        fv = 2'b11; frd[0] = 5; fd[0] = 32'h11; frd[1] = 5; fd[1] = 32'h22;
        src1_sel = 2'd0; src2_sel = 2'd1; imm = 32'h7;
        tick();
        check("prio_op1", ex_op1, 32'h11);
        check("prio_valid", ex_valid, 1);

        // Load-use on x6: one bubble, then forwarded data.
        set_idle();
        id_valid = 1; rs1_addr = 6; rs1_used = 1; rs1_data = 32'h5;
        fv = 2'b01; frd[0] = 6; fpend = 2'b01;
        c0 = m_cnt;
        tick();
        check("lu_cnt", stall_cnt, c0 + 1);
        fpend = 2'b00; fd[0] = 32'h66;
        tick();
        check("lu_op1", ex_op1, 32'h66);
        check("lu_valid", ex_valid, 1);

        // Pending write to x0 is ignored.
        set_idle();
        id_valid = 1; rs2_addr = 0; rs2_used = 1; rs2_data = 32'h77;
        fv = 2'b01; frd[0] = 0; fd[0] = 32'hDEAD; fpend = 2'b01;
        src2_sel = 2'd0;
        tick();
        check("x0_op2", ex_op2, 0);

        // JAL operands.
        set_idle();
        id_valid = 1; pc = 32'h100; src1_sel = 2'd1; src2_sel = 2'd2;
        tick();
        check("jal_op1", ex_op1, 32'h100);
        check("jal_op2", ex_op2, 32'h4);

        // Backpressure for 3 cycles with a flush in the second.
        set_idle();
        id_valid = 1; pc = 32'h200; src1_sel = 2'd1;
        tick();
        pc = 32'h300; ex_ready = 0;
        tick();
        check("hold_op1", ex_op1, 32'h200);
        flush = 1;
        tick();
        check("flush_valid", ex_valid, 0);
        flush = 0;
        tick();

        for (int i = 0; i < 3000; i++) begin
            drive_random();
            tick();
        end

        // Saturate the stall counter.
        set_idle();
        id_valid = 1; rs1_addr = 9; rs1_used = 1;
        fv = 2'b01; frd[0] = 9; fpend = 2'b01;
        tick();
        repeat (CMAX + 5) @(negedge clk);
        m_cnt = CMAX;
        tick();
        check("cnt_sat", stall_cnt, CMAX);
        tick();

        // Fill EX, stall again, then reset mid-cycle.
        fpend = 2'b00; fd[0] = 32'hABCD1234; ex_ready = 0;
        tick();
        fpend = 2'b01;
        tick();
        #2;
        rst_n = 0;
        #1;
        check("arst_valid", ex_valid, 0);
        check("arst_op1", ex_op1, 0);
        check("arst_rs1", ex_rs1_val, 0);
        check("arst_cnt", stall_cnt, 0);
        model_reset();
        set_idle();
        @(negedge clk);
        rst_n = 1;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
